// File: rtl/varredura_display.sv
// Four-digit multiplexed seven-segment scanner: per-scan snapshot, leading-zero
// blanking, and a blank guard interval at the start of every digit slot.
module varredura_display #(
    parameter int unsigned DIVISOR = 50000,
    parameter int unsigned GUARDA  = 2
) (
    input  logic        clock_inicial,
    input  logic        reset,
    input  logic [15:0] valor,
    input  logic [3:0]  pontos,
    input  logic        apagar_zeros,
    output logic [3:0]  an,
    output logic        a,
    output logic        b,
    output logic        c,
    output logic        d,
    output logic        e,
    output logic        f,
    output logic        g,
    output logic        dp
);

    localparam int unsigned NW = $clog2(DIVISOR);

    if (DIVISOR < 4 || GUARDA < 1 || GUARDA >= DIVISOR) begin : g_param_check
        $error("varredura_display: invalid DIVISOR/GUARDA");
    end

    logic [NW-1:0] r_n;
    logic [1:0]    r_i;
    logic [15:0]   r_valor;
    logic [3:0]    r_pontos;
    logic          r_apagar;
    logic [3:0]    r_an;
    logic [6:0]    r_seg;
    logic          r_dp;

    logic          w_last;
    logic          w_scan_start;
    logic [3:0]    w_digit;
    logic          w_blank_digit;
    logic          w_active;
    logic [6:0]    w_lit;
    logic [3:0]    w_an;
    logic [6:0]    w_seg;
    logic          w_dp;

    assign w_last       = (r_n == NW'(DIVISOR - 1));
    assign w_scan_start = (r_n == '0) && (r_i == 2'd0);
    assign w_digit      = r_valor[{r_i, 2'b00} +: 4];

    // A digit is blanked when it and every digit above it are zero; digit 0 always shows.
    always_comb begin
        w_blank_digit = 1'b0;
        case (r_i)
            2'd1:    w_blank_digit = r_apagar && (r_valor[15:4]  == 12'h000);
            2'd2:    w_blank_digit = r_apagar && (r_valor[15:8]  == 8'h00);
            2'd3:    w_blank_digit = r_apagar && (r_valor[15:12] == 4'h0);
            default: w_blank_digit = 1'b0;
        endcase
    end

    // Lit-segment pattern, bit order {a,b,c,d,e,f,g}.
    always_comb begin
        w_lit = 7'b0000000;
        case (w_digit)
            4'h0:    w_lit = 7'b1111110;
            4'h1:    w_lit = 7'b0110000;
            4'h2:    w_lit = 7'b1101101;
            4'h3:    w_lit = 7'b1111001;
            4'h4:    w_lit = 7'b0110011;
            4'h5:    w_lit = 7'b1011011;
            4'h6:    w_lit = 7'b1011111;
            4'h7:    w_lit = 7'b1110000;
            4'h8:    w_lit = 7'b1111111;
            4'h9:    w_lit = 7'b1111011;
            4'hA:    w_lit = 7'b1110111;
            4'hB:    w_lit = 7'b0011111;
            4'hC:    w_lit = 7'b1001110;
            4'hD:    w_lit = 7'b0111101;
            4'hE:    w_lit = 7'b1001111;
            default: w_lit = 7'b1000111;
        endcase
    end

    assign w_active = (r_n >= NW'(GUARDA)) && !w_blank_digit;

    always_comb begin
        w_an  = 4'hF;
        w_seg = 7'h7F;
        w_dp  = 1'b1;
        if (w_active) begin
            w_an  = ~(4'b0001 << r_i);
            w_seg = ~w_lit;
            w_dp  = ~r_pontos[r_i];
        end
    end

    always_ff @(posedge clock_inicial or posedge reset) begin
        if (reset) begin
            r_n      <= '0;
            r_i      <= 2'd0;
            r_valor  <= 16'h0000;
            r_pontos <= 4'h0;
            r_apagar <= 1'b0;
            r_an     <= 4'hF;
            r_seg    <= 7'h7F;
            r_dp     <= 1'b1;
        end else begin
            r_n <= w_last ? '0 : r_n + NW'(1);
            if (w_last) begin
                r_i <= r_i + 2'd1;
            end
            if (w_scan_start) begin
                r_valor  <= valor;
                r_pontos <= pontos;
                r_apagar <= apagar_zeros;
            end
            r_an  <= w_an;
            r_seg <= w_seg;
            r_dp  <= w_dp;
        end
    end

    assign an = r_an;
    assign a  = r_seg[6];
    assign b  = r_seg[5];
    assign c  = r_seg[4];
    assign d  = r_seg[3];
    assign e  = r_seg[2];
    assign f  = r_seg[1];
    assign g  = r_seg[0];
    assign dp = r_dp;

endmodule

// File: tb/tb_varredura_display.sv
// Randomized and directed bench for varredura_display against an edge-indexed
// reference model (DIVISOR = 8, GUARDA = 2).
module tb_varredura_display;

    localparam int D = 8;
    localparam int G = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] valor;
    logic [3:0]  pontos;
    logic        apagar_zeros;
    logic [3:0]  an;
    logic        a, b, c, d, e, f, g, dp;

    int n_checks = 0;
    int n_errors = 0;

    // Model state: edges since reset release and the snapshot the display should be using.
    int          k;
    logic [15:0] m_valor;
    logic [3:0]  m_pontos;
    logic        m_apagar;

    string pat [16] = '{"abcdef", "bc", "abdeg", "abcdg", "bcfg", "acdfg", "acdefg", "abc",
                        "abcdefg", "abcdfg", "abcefg", "cdefg", "adef", "bcdeg", "adefg", "aefg"};

    always #5 clk = ~clk;

    varredura_display #(.DIVISOR(D), .GUARDA(G)) dut (
        .clock_inicial (clk),
        .reset         (rst),
        .valor         (valor),
        .pontos        (pontos),
        .apagar_zeros  (apagar_zeros),
        .an            (an),
        .a             (a),
        .b             (b),
        .c             (c),
        .d             (d),
        .e             (e),
        .f             (f),
        .g             (g),
        .dp            (dp)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s at k=%0d: got %h expected %h", tag, k, got, exp);
        end
    endtask

    // Segment letters -> {a..g} lit mask.
    function automatic logic [6:0] lit_mask(input int v);
        logic [6:0] m;
        string      s;
        m = '0;
        s = pat[v];
        for (int j = 0; j < s.len(); j++) begin
            m[6 - (int'(s[j]) - int'("a"))] = 1'b1;
        end
        return m;
    endfunction

    task automatic check_blank(input string tag);
        check({tag, "_an"}, 32'(an), 32'hF);
        check({tag, "_seg"}, 32'({a, b, c, d, e, f, g}), 32'h7F);
        check({tag, "_dp"}, 32'(dp), 32'h1);
    endtask

    // One clock edge: predict, advance, compare.
    task automatic step();
        int         n, i, hi, dig;
        logic [3:0] e_an;
        logic [6:0] e_seg;
        logic       e_dp;
        n  = k % D;
        i  = (k / D) % 4;
        hi = 0;
        for (int j = 0; j < 4; j++) begin
            if (((m_valor >> (4 * j)) & 16'hF) != 0) hi = j;
        end
        dig   = int'((m_valor >> (4 * i)) & 16'hF);
        e_an  = 4'hF;
        e_seg = 7'h7F;
        e_dp  = 1'b1;
        if (n >= G && !(m_apagar && i > hi)) begin
            e_an  = 4'hF ^ (4'b0001 << i);
            e_seg = ~lit_mask(dig);
            e_dp  = ~m_pontos[i];
        end
        if (n == 0 && i == 0) begin
            m_valor  = valor;
            m_pontos = pontos;
            m_apagar = apagar_zeros;
        end
        @(posedge clk);
        #1;
        check("an", 32'(an), 32'(e_an));
        check("seg", 32'({a, b, c, d, e, f, g}), 32'(e_seg));
        check("dp", 32'(dp), 32'(e_dp));
        check("an_onehot", 32'($countones(~an) <= 1), 32'h1);
        k++;
    endtask

    task automatic run(input int cycles);
        for (int c2 = 0; c2 < cycles; c2++) step();
    endtask

    task automatic run_until_pos(input int pos);
        for (int t = 0; t < 8 * D && (k % (4 * D)) != pos; t++) step();
        check("reach_pos", 32'(k % (4 * D)), 32'(pos));
    endtask

    task automatic release_reset();
        rst      = 1'b0;
        k        = 0;
        m_valor  = 16'h0;
        m_pontos = 4'h0;
        m_apagar = 1'b0;
    endtask

    initial begin
        rst          = 1'b1;
        valor        = 16'hFFFF;
        pontos       = 4'hF;
        apagar_zeros = 1'b0;
        k            = 0;
        #1;
        check_blank("reset_async");
        for (int r = 0; r < 20; r++) begin
            @(posedge clk);
            #1;
            check_blank("reset_hold");
        end

        // Basic scan timing
        valor = 16'h1234; pontos = 4'h0; apagar_zeros = 1'b0;
        release_reset();
        run(8 * D);

        // Leading-zero blanking
        valor = 16'h0050; apagar_zeros = 1'b1;
        run_until_pos(0);
        run(8 * D);
        valor = 16'h0000;
        run(8 * D);
        apagar_zeros = 1'b0;
        run(8 * D);

        // Mid-scan input change must not tear
        valor = 16'h1111;
        run_until_pos(0);
        run(D + 3);
        valor = 16'h2222;
        run(8 * D);

        // Decimal points
        valor = 16'hABCD; pontos = 4'b0101;
        run(8 * D);

        // Reset pulse while digit 2 is lit
        valor = 16'h1234; pontos = 4'h0;
        run_until_pos(2 * D + 4);
        check("pre_reset_an", 32'(an), 32'hB);
        #2;
        rst = 1'b1;
        #1;
        check_blank("reset_mid");
        @(posedge clk);
        #1;
        check_blank("reset_mid_hold");
        #2;
        release_reset();
        run(8 * D);

        // Randomized inputs changed at random points
        for (int it = 0; it < 40; it++) begin
            valor        = 16'($urandom);
            if ($urandom_range(0, 2) == 0) valor = valor & 16'h00FF;
            if ($urandom_range(0, 3) == 0) valor = valor & 16'h000F;
            pontos       = 4'($urandom);
            apagar_zeros = 1'($urandom);
            run(int'($urandom_range(1, 3 * D)));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
